// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE output stage: FSM state encoding,
// accumulator clamp limits and sign extension.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    // Limits are returned as 64-bit patterns; callers keep the low `width` bits.
    function automatic logic [63:0] acc_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

    // Sign-extends the low `width` bits of `value` to the full 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] value, input int width);
        return 64'($signed(value << (64 - width)) >>> (64 - width));
    endfunction

endpackage

// File: rtl/csla.sv
// Carry-select adder: a ripple-carry low block followed by PRE_UNIT_NUM blocks
// that precompute both carry-in cases and select on the incoming carry.
module csla #(
    parameter int WIDTH        = 32,
    parameter int RCA_WIDTH    = 8,
    parameter int PRE_WIDTH    = 6,
    parameter int PRE_UNIT_NUM = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    logic [PRE_UNIT_NUM:0] carry;

    assign {carry[0], sum[RCA_WIDTH-1:0]} =
        {1'b0, a[RCA_WIDTH-1:0]} + {1'b0, b[RCA_WIDTH-1:0]};

    for (genvar u = 0; u < PRE_UNIT_NUM; u++) begin : g_unit
        localparam int LO = RCA_WIDTH + u * PRE_WIDTH;
        logic [PRE_WIDTH:0] sum_c0;
        logic [PRE_WIDTH:0] sum_c1;

        assign sum_c0 = {1'b0, a[LO +: PRE_WIDTH]} + {1'b0, b[LO +: PRE_WIDTH]};
        assign sum_c1 = {1'b0, a[LO +: PRE_WIDTH]} + {1'b0, b[LO +: PRE_WIDTH]}
                      + {{PRE_WIDTH{1'b0}}, 1'b1};

        assign sum[LO +: PRE_WIDTH] = carry[u] ? sum_c1[PRE_WIDTH-1:0] : sum_c0[PRE_WIDTH-1:0];
        assign carry[u+1]           = carry[u] ? sum_c1[PRE_WIDTH]     : sum_c0[PRE_WIDTH];
    end

    assign sum[WIDTH] = carry[PRE_UNIT_NUM];

endmodule

// File: rtl/pe_acc_drain.sv
// Tile accumulator at the adder-tree output: saturating signed accumulation of
// partial sums, then a held result on a valid/ready bus to the collector.
module pe_acc_drain
    import pe_pkg::*;
#(
    parameter int IN_WIDTH  = 29,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam logic [63:0]          MAX_WIDE = acc_max(ACC_WIDTH);
    localparam logic [63:0]          MIN_WIDE = acc_min(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = MAX_WIDE[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = MIN_WIDE[ACC_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam int                   MSB      = ACC_WIDTH - 1;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;

    logic [63:0]          in_sext_wide;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] sum_raw;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 overflow;
    logic                 accept;
    logic                 unused_bits;

    assign in_sext_wide = sext(64'(in_data), IN_WIDTH);
    assign in_ext       = in_sext_wide[ACC_WIDTH-1:0];

    csla #(
        .WIDTH        (ACC_WIDTH),
        .RCA_WIDTH    (8),
        .PRE_WIDTH    (6),
        .PRE_UNIT_NUM (4)
    ) u_csla (
        .a   (acc),
        .b   (in_ext),
        .sum (sum_full)
    );

    // The adder carry-out says nothing about signed overflow, so it is dropped.
    assign sum_raw     = sum_full[ACC_WIDTH-1:0];
    assign unused_bits = ^{in_sext_wide[63:ACC_WIDTH], sum_full[ACC_WIDTH]};

    assign overflow = (acc[MSB] == in_ext[MSB]) && (sum_raw[MSB] != acc[MSB]);
    assign sum_sat  = overflow ? (acc[MSB] ? ACC_MIN : ACC_MAX) : sum_raw;

    // A draining result frees the stage in the same cycle, so a new tile can start.
    assign in_ready = (state != HOLD) || out_ready;
    assign accept   = in_valid && in_ready;

    assign out_valid = (state == HOLD);
    assign out_data  = acc;
    assign out_sat   = sat;
    assign out_count = cnt;

    // NOTE: the accumulator is a plain register, so clearing it on reset is cheap
    // and keeps out_data at zero after reset; all state uses non-blocking updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else if (accept) begin
            if (state == ACC) begin
                acc <= sum_sat;
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                sat <= sat | overflow;
            end else begin
                acc <= in_ext;
                cnt <= CNT_ONE;
                sat <= 1'b0;
            end
            state <= in_last ? HOLD : ACC;
        end else if (state == HOLD && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_pe_acc_drain.sv
// Self-checking bench for pe_acc_drain: tile table plus hand-written stall and
// reset sequences, results checked against a queue of expected tile results.
module tb_pe_acc_drain;

    localparam int IW = 29;
    localparam int AW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_sat;
    logic [CW-1:0] out_count;

    pe_acc_drain #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] data;
        logic          sat;
        logic [CW-1:0] cnt;
    } res_t;

    typedef struct {
        int            n;
        int            v_first;
        int            v_mid;
        int            v_last;
        logic [AW-1:0] exp_data;
        logic          exp_sat;
        logic [CW-1:0] exp_cnt;
    } tile_t;

    res_t  sb[$];
    tile_t tiles[9];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: samples just before the rising edge where the handshake lands.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: actual=0x%0h expected=none at %0t", out_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("res_data",  64'(out_data),  64'(e.data));
                    check("res_sat",   64'(out_sat),   64'(e.sat));
                    check("res_count", 64'(out_count), 64'(e.cnt));
                end
            end
        end
    end

    // Drives one beat from negedge+1 and returns at negedge+1 after acceptance.
    task automatic send(input int d, input logic last);
        logic rdy;
        int   tries;
        tries    = 0;
        in_valid = 1'b1;
        in_data  = d[IW-1:0];
        in_last  = last;
        do begin
            #1;
            rdy = in_ready;
            @(negedge clk);
            #1;
            tries++;
        end while (!rdy && tries < 200);
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: actual=in_ready_low expected=accept at %0t", $time);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_tile(input tile_t t);
        int d;
        for (int i = 0; i < t.n; i++) begin
            d = (i == 0) ? t.v_first : ((i == t.n - 1) ? t.v_last : t.v_mid);
            if (i == t.n - 1) sb.push_back('{t.exp_data, t.exp_sat, t.exp_cnt});
            send(d, i == t.n - 1);
        end
    endtask

    initial begin
        tiles[0] = '{3,   5,          -3,         10, 32'd12,         1'b0, 8'd3};
        tiles[1] = '{1,   -1,         0,          0,  32'hFFFF_FFFF,  1'b0, 8'd1};
        tiles[2] = '{10,  268435455,  268435455,  -5, 32'h7FFF_FFFA,  1'b1, 8'd10};
        tiles[3] = '{2,   100,        0,          -40, 32'd60,        1'b0, 8'd2};
        tiles[4] = '{10,  -268435456, -268435456, 3,  32'h8000_0003,  1'b1, 8'd10};
        tiles[5] = '{9,   268435455,  268435455,  7,  32'h7FFF_FFFF,  1'b0, 8'd9};
        tiles[6] = '{4,   -268435456, 268435455,  -7, 32'h0FFF_FFF7,  1'b0, 8'd4};
        tiles[7] = '{255, 1,          1,          1,  32'd255,        1'b0, 8'd255};
        tiles[8] = '{300, 1,          1,          1,  32'd300,        1'b0, 8'd255};

        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state, with in_ready already high while reset is held.
        @(negedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_sat",   64'(out_sat),   64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;

        // Table of tiles, back to back with continuous out_ready.
        foreach (tiles[k]) run_tile(tiles[k]);
        repeat (3) begin
            @(negedge clk);
            #1;
        end

        // Result held under backpressure while upstream keeps a beat pending.
        out_ready = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        sb.push_back('{32'd6, 1'b0, 8'd3});
        send(3, 1'b1);
        in_valid = 1'b1;
        in_data  = 29'd7;
        in_last  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data",  64'(out_data),  64'd6);
            check("stall_in_ready",  64'(in_ready),  64'd0);
            @(negedge clk);
            #1;
        end
        sb.push_back('{32'd7, 1'b0, 8'd1});
        out_ready = 1'b1;
        send(7, 1'b1);
        repeat (2) begin
            @(negedge clk);
            #1;
        end

        // Reset in the middle of an open tile.
        send(9, 1'b0);
        send(9, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_acc_out_valid", 64'(out_valid), 64'd0);
        check("rst_acc_out_count", 64'(out_count), 64'd0);
        check("rst_acc_out_data",  64'(out_data),  64'd0);
        check("rst_acc_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Reset while a result is held: it must vanish without being emitted.
        out_ready = 1'b0;
        send(5, 1'b1);
        #1;
        check("hold_before_rst", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_hold_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        sb.push_back('{32'd4, 1'b0, 8'd1});
        send(4, 1'b1);

        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
